// File: rtl/aes128_iter_encrypt_ctrl_if.sv
// Valid/ready bus and status signals for the iterative AES-128 controller.
interface aes128_iter_encrypt_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [3:0]   round_cnt;

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data, busy, round_cnt
  );

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data, busy, round_cnt
  );
endinterface

// File: rtl/aes128_iter_encrypt_ctrl.sv
// Iterative AES-128 encryption: one shared round datapath, on-the-fly key
// expansion, one block in flight, valid/ready on both sides.
module aes128_iter_encrypt_ctrl (
  input logic                        clk,
  input logic                        rst_n,
  aes128_iter_encrypt_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [1:0]   r_state;
  logic [127:0] r_st;
  logic [127:0] r_rk;
  logic [7:0]   r_rcon;
  logic [3:0]   r_round_cnt;
  logic         r_out_valid;
  logic [127:0] r_out_data;

  logic [127:0] w_next_rk;
  logic [127:0] w_sub_shift;
  logic [127:0] w_round_out;
  logic [127:0] w_final_out;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    // 8*(255-b) == {~b, 3'b000}
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte n (row n%4, column n/4) lives at bits [127-8n -: 8].
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[(15 - (r + 4*c))*8 +: 8] = sbox(s[(15 - (r + 4*((c + r) % 4)))*8 +: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[(15 - 4*c)*8 +: 8];
      a1 = s[(14 - 4*c)*8 +: 8];
      a2 = s[(13 - 4*c)*8 +: 8];
      a3 = s[(12 - 4*c)*8 +: 8];
      o[(15 - 4*c)*8 +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[(14 - 4*c)*8 +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[(13 - 4*c)*8 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[(12 - 4*c)*8 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  always_comb begin
    logic [31:0] w0, w1, w2, w3, nk0, nk1, nk2, nk3;
    w0 = r_rk[127:96];
    w1 = r_rk[95:64];
    w2 = r_rk[63:32];
    w3 = r_rk[31:0];
    nk0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {r_rcon, 24'h0};
    nk1 = nk0 ^ w1;
    nk2 = nk1 ^ w2;
    nk3 = nk2 ^ w3;
    w_next_rk   = {nk0, nk1, nk2, nk3};
    w_sub_shift = sub_shift(r_st);
    w_round_out = mix_columns(w_sub_shift) ^ w_next_rk;
    w_final_out = w_sub_shift ^ w_next_rk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_st        <= '0;
      r_rk        <= '0;
      r_rcon      <= '0;
      r_round_cnt <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_st        <= bus.in_data ^ bus.in_key;
            r_rk        <= bus.in_key;
            r_rcon      <= 8'h01;
            r_round_cnt <= 4'd1;
            r_state     <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_st        <= w_round_out;
          r_rk        <= w_next_rk;
          r_rcon      <= xtime(r_rcon);
          r_round_cnt <= r_round_cnt + 4'd1;
          if (r_round_cnt == 4'd9) r_state <= S_FINAL;
        end
        S_FINAL: begin
          r_st        <= w_final_out;
          r_rk        <= w_next_rk;
          r_out_data  <= w_final_out;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_round_cnt <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.round_cnt = r_round_cnt;

endmodule

// File: tb/tb_aes128_iter_encrypt_ctrl.sv
// Directed bench for aes128_iter_encrypt_ctrl using FIPS-197 known answers.
module tb_aes128_iter_encrypt_ctrl;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK1_B = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  aes128_iter_encrypt_ctrl_if bus ();

  aes128_iter_encrypt_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  128'(bus.in_ready),  128'd1);
    chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'd0);
    chk({tag, "_out_data"},  bus.out_data,        128'd0);
    chk({tag, "_busy"},      128'(bus.busy),      128'd0);
    chk({tag, "_round_cnt"}, 128'(bus.round_cnt), 128'd0);
  endtask

  // Waits (bounded) for IDLE, presents one block for exactly the accept edge.
  task automatic accept(input logic [127:0] pt, input logic [127:0] key, input string tag);
    int n;
    n = 0;
    while (!bus.in_ready && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_ready_before_accept"}, 128'(bus.in_ready), 128'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = pt;
    bus.in_key   = key;
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = '1;
    bus.in_key   = '1;
    chk({tag, "_round1"}, 128'(bus.round_cnt), 128'd1);
  endtask

  // Counts cycles until out_valid (bounded) and checks latency and ciphertext.
  task automatic wait_out(input int exp_cycles, input logic [127:0] exp_ct, input string tag);
    int n;
    n = 0;
    while (!bus.out_valid && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'(exp_cycles));
    chk({tag, "_ct"}, bus.out_data, exp_ct);
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    step();
    chk({tag, "_idle_after_xfer"}, 128'(bus.in_ready), 128'd1);
    chk({tag, "_ov_dropped"}, 128'(bus.out_valid), 128'd0);
  endtask

  initial begin
    logic [127:0] held;
    int           n;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_key    = '0;
    bus.out_ready = 1'b1;

    step();
    chk_reset_outputs("reset");
    step();
    rst_n = 1'b1;
    step();

    // App. B with internal round-key check after the first round.
    accept(PT_B, KEY_B, "appB");
    step();
    chk("appB_rk1", dut.r_rk, RK1_B);
    chk("appB_busy", 128'(bus.busy), 128'd1);
    wait_out(9, CT_B, "appB");
    chk("appB_round_cnt_done", 128'(bus.round_cnt), 128'd10);
    drain("appB");
    chk("appB_round_cnt_idle", 128'(bus.round_cnt), 128'd0);

    accept(PT_C, KEY_C, "appC");
    wait_out(10, CT_C, "appC");
    drain("appC");

    accept('0, '0, "zero");
    wait_out(10, CT_Z, "zero");
    drain("zero");

    // Backpressure: output must hold in DONE.
    bus.out_ready = 1'b0;
    accept(PT_B, KEY_B, "bp");
    wait_out(10, CT_B, "bp");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_data_stable", bus.out_data, CT_B);
      chk("bp_valid_held", 128'(bus.out_valid), 128'd1);
      chk("bp_busy", 128'(bus.busy), 128'd1);
      chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
      chk("bp_round_cnt", 128'(bus.round_cnt), 128'd10);
    end
    drain("bp");

    // in_valid activity during a block is ignored; a held request is taken at first IDLE cycle.
    accept(PT_C, KEY_C, "rej");
    for (int i = 1; i <= 10; i++) begin
      bus.in_valid = (i % 2) == 1;
      bus.in_data  = 128'hdeadbeef_0badf00d_12345678_9abcdef0 + 128'(i);
      bus.in_key   = 128'hcafebabe_00000000_ffffffff_55aa55aa ^ 128'(i);
      step();
    end
    chk("rej_out_valid", 128'(bus.out_valid), 128'd1);
    chk("rej_ct", bus.out_data, CT_C);
    chk("rej_round_cnt", 128'(bus.round_cnt), 128'd10);
    bus.in_valid = 1'b1;
    bus.in_data  = '0;
    bus.in_key   = '0;
    step();
    chk("rej_idle", 128'(bus.in_ready), 128'd1);
    chk("rej_ov_low", 128'(bus.out_valid), 128'd0);
    step();
    chk("rej_held_accepted", 128'(bus.in_ready), 128'd0);
    chk("rej_held_round1", 128'(bus.round_cnt), 128'd1);
    bus.in_valid = 1'b0;
    wait_out(10, CT_Z, "rej_second");
    drain("rej_second");

    // Asynchronous reset in the middle of a block.
    accept(PT_B, KEY_B, "mid");
    for (int i = 0; i < 4; i++) step();
    chk("mid_round5", 128'(bus.round_cnt), 128'd5);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_async");
    step();
    chk_reset_outputs("mid_held");
    rst_n = 1'b1;
    step();
    accept(PT_B, KEY_B, "post_rst");
    wait_out(10, CT_B, "post_rst");
    drain("post_rst");

    // Back-to-back with in_valid and out_ready held high.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = PT_C;
    bus.in_key    = KEY_C;
    step();
    chk("b2b_first_accept", 128'(bus.round_cnt), 128'd1);
    bus.in_data = PT_B;
    bus.in_key  = KEY_B;
    n = 0;
    held = '0;
    while (!bus.out_valid && n < 30) begin
      step();
      n++;
    end
    chk("b2b_first_latency", 128'(n), 128'd10);
    chk("b2b_first_ct", bus.out_data, CT_C);
    while (!(bus.busy && bus.round_cnt == 4'd1) && n < 40) begin
      step();
      n++;
    end
    chk("b2b_accept_spacing", 128'(n), 128'd12);
    bus.in_valid = 1'b0;
    wait_out(10, CT_B, "b2b_second");
    held = bus.out_data;
    drain("b2b_second");
    chk("b2b_second_held", held, CT_B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
